// File: rtl/amp_cfg_sequencer.sv
// Serial configuration master for the class-D amplifier: shifts a fixed word
// table out over CSN/SCK/MOSI (mode 0, MSB first), checks the fault line and retries.
module amp_cfg_sequencer #(
    parameter int NUM_WORDS = 4,
    parameter int WORD_W    = 16,
    parameter int CLK_DIV   = 4,
    parameter int GAP_CYC   = 8,
    parameter int MAX_RETRY = 2,
    parameter logic [NUM_WORDS*WORD_W-1:0] CFG_TABLE = {16'h1234, 16'h8001, 16'h0F0F, 16'hA5C3}
) (
    input  logic clk_in,
    input  logic resetb,
    input  logic start_in,
    input  logic nerror_in,
    output logic spi_csn_out,
    output logic spi_sck_out,
    output logic spi_mosi_out,
    output logic cfg_busy_out,
    output logic cfg_done_out,
    output logic cfg_fail_out
);

    localparam int IDX_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int BIT_W   = $clog2(WORD_W + 1);
    localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TBL_N   = 2 ** IDX_W;

    typedef enum logic [3:0] {
        IDLE, LOAD, CS_SETUP, SHIFT_HI, SHIFT_LO, CS_HOLD, GAP, CHECK, DONE, FAIL
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [IDX_W-1:0]   word_idx_reg, word_idx_next;
    logic [RTY_W-1:0]   retry_reg, retry_next;
    logic [BIT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [WORD_W-1:0]  shift_reg, shift_next;
    logic               start_q_reg;
    logic               csn_reg, csn_next;
    logic               sck_reg, sck_next;
    logic               mosi_reg, mosi_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               fail_reg, fail_next;

    logic [WORD_W-1:0]  table_words [TBL_N];
    logic [WORD_W-1:0]  load_word;
    logic [WORD_W-1:0]  shifted;
    logic               div_end;
    logic               gap_end;

    // Table padded to a power of two so the word index addresses it exactly.
    generate
        for (genvar gi = 0; gi < TBL_N; gi++) begin : g_table
            if (gi < NUM_WORDS) begin : g_word
                assign table_words[gi] = CFG_TABLE[gi*WORD_W +: WORD_W];
            end else begin : g_pad
                assign table_words[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        word_idx_next = word_idx_reg;
        retry_next    = retry_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        csn_next      = csn_reg;
        sck_next      = sck_reg;
        mosi_next     = mosi_reg;
        busy_next     = busy_reg;
        done_next     = done_reg;
        fail_next     = fail_reg;
        load_word     = table_words[word_idx_reg];
        shifted       = shift_reg << 1;
        div_end       = (cnt_reg == CNT_W'(CLK_DIV - 1));
        gap_end       = (cnt_reg == CNT_W'(GAP_CYC - 1));

        case (state_reg)
            IDLE: begin
                if (start_in && !start_q_reg) begin
                    state_next    = LOAD;
                    word_idx_next = '0;
                    retry_next    = '0;
                    busy_next     = 1'b1;
                end
            end
            LOAD: begin
                shift_next   = load_word;
                bit_cnt_next = BIT_W'(WORD_W);
                csn_next     = 1'b0;
                mosi_next    = load_word[WORD_W-1];
                cnt_next     = '0;
                state_next   = CS_SETUP;
            end
            CS_SETUP: begin
                if (div_end) begin
                    cnt_next   = '0;
                    sck_next   = 1'b1;
                    state_next = SHIFT_HI;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (div_end) begin
                    cnt_next     = '0;
                    sck_next     = 1'b0;
                    shift_next   = shifted;
                    bit_cnt_next = bit_cnt_reg - 1'b1;
                    // MOSI returns low once the final bit has been clocked out.
                    mosi_next    = (bit_cnt_reg == BIT_W'(1)) ? 1'b0 : shifted[WORD_W-1];
                    state_next   = SHIFT_LO;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            SHIFT_LO: begin
                if (div_end) begin
                    cnt_next = '0;
                    if (bit_cnt_reg != '0) begin
                        sck_next   = 1'b1;
                        state_next = SHIFT_HI;
                    end else begin
                        state_next = CS_HOLD;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            CS_HOLD: begin
                if (div_end) begin
                    cnt_next   = '0;
                    csn_next   = 1'b1;
                    state_next = GAP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            GAP: begin
                if (gap_end) begin
                    cnt_next = '0;
                    if (word_idx_reg < IDX_W'(NUM_WORDS - 1)) begin
                        word_idx_next = word_idx_reg + 1'b1;
                        state_next    = LOAD;
                    end else begin
                        state_next = CHECK;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            CHECK: begin
                if (nerror_in) begin
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = DONE;
                end else if (retry_reg < RTY_W'(MAX_RETRY)) begin
                    retry_next    = retry_reg + 1'b1;
                    word_idx_next = '0;
                    state_next    = LOAD;
                end else begin
                    busy_next  = 1'b0;
                    fail_next  = 1'b1;
                    state_next = FAIL;
                end
            end
            DONE: begin
                if (!start_in) begin
                    done_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            FAIL: begin
                if (!start_in) begin
                    fail_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!resetb) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            word_idx_reg <= '0;
            retry_reg    <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            start_q_reg  <= 1'b0;
            csn_reg      <= 1'b1;
            sck_reg      <= 1'b0;
            mosi_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            fail_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            word_idx_reg <= word_idx_next;
            retry_reg    <= retry_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            start_q_reg  <= start_in;
            csn_reg      <= csn_next;
            sck_reg      <= sck_next;
            mosi_reg     <= mosi_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            fail_reg     <= fail_next;
        end
    end

    assign spi_csn_out  = csn_reg;
    assign spi_sck_out  = sck_reg;
    assign spi_mosi_out = mosi_reg;
    assign cfg_busy_out = busy_reg;
    assign cfg_done_out = done_reg;
    assign cfg_fail_out = fail_reg;

endmodule

// File: tb/tb_amp_cfg_sequencer.sv
// Bench for amp_cfg_sequencer: SPI link decoder plus a pass/retry model driven
// by random fault patterns and start glitches; a second tiny instance covers CLK_DIV=1.
module tb_amp_cfg_sequencer;

    localparam int NUM_WORDS = 4;
    localparam int WORD_W    = 16;
    localparam int CLK_DIV   = 4;
    localparam int GAP_CYC   = 8;
    localparam int MAX_RETRY = 2;
    localparam int WORD_CYC  = 1 + CLK_DIV + 2*CLK_DIV*WORD_W + CLK_DIV + GAP_CYC;
    localparam int PASS_CYC  = NUM_WORDS*WORD_CYC + 1;

    logic [15:0] ref_table [4] = '{16'hA5C3, 16'h0F0F, 16'h8001, 16'h1234};

    logic clk;
    logic resetb;
    logic start;
    logic nerror;
    logic csn, sck, mosi, busy, done, fail;
    logic s_start, s_nerror;
    logic s_csn, s_sck, s_mosi, s_busy, s_done, s_fail;

    int vec_cnt = 0;
    int err_cnt = 0;

    // link decoder state
    int          mon_bits  = 0;
    int          mon_words = 0;
    int          hi_run    = 0;
    int          lo_run    = 0;
    bit          lo_valid  = 0;
    logic        csn_prev  = 1'b1;
    logic        sck_prev  = 1'b0;
    logic [15:0] mon_word  = '0;
    logic [15:0] got_q [$];

    amp_cfg_sequencer #(
        .NUM_WORDS(NUM_WORDS), .WORD_W(WORD_W), .CLK_DIV(CLK_DIV),
        .GAP_CYC(GAP_CYC), .MAX_RETRY(MAX_RETRY),
        .CFG_TABLE({16'h1234, 16'h8001, 16'h0F0F, 16'hA5C3})
    ) u_dut (
        .clk_in(clk), .resetb(resetb), .start_in(start), .nerror_in(nerror),
        .spi_csn_out(csn), .spi_sck_out(sck), .spi_mosi_out(mosi),
        .cfg_busy_out(busy), .cfg_done_out(done), .cfg_fail_out(fail)
    );

    amp_cfg_sequencer #(
        .NUM_WORDS(1), .WORD_W(8), .CLK_DIV(1), .GAP_CYC(8), .MAX_RETRY(2),
        .CFG_TABLE(8'h81)
    ) u_small (
        .clk_in(clk), .resetb(resetb), .start_in(s_start), .nerror_in(s_nerror),
        .spi_csn_out(s_csn), .spi_sck_out(s_sck), .spi_mosi_out(s_mosi),
        .cfg_busy_out(s_busy), .cfg_done_out(s_done), .cfg_fail_out(s_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Decodes each CSN-low window into a word and checks SCK phase widths.
    always begin
        @(negedge clk);
        if (!resetb) begin
            mon_bits = 0; hi_run = 0; lo_run = 0; lo_valid = 0;
            csn_prev = 1'b1; sck_prev = 1'b0;
        end else begin
            if (csn_prev && !csn) begin
                mon_bits = 0; mon_word = '0; lo_valid = 0;
            end
            if (!csn) begin
                if (sck && !sck_prev) begin
                    mon_word = {mon_word[14:0], mosi};
                    mon_bits++;
                    if (lo_valid) check_val("sck_low_width", lo_run, CLK_DIV);
                    hi_run = 1;
                end else if (sck) begin
                    hi_run++;
                end else if (sck_prev) begin
                    check_val("sck_high_width", hi_run, CLK_DIV);
                    lo_run = 1; lo_valid = 1;
                end else begin
                    lo_run++;
                end
            end
            if (!csn_prev && csn) begin
                check_val("word_bits", mon_bits, WORD_W);
                got_q.push_back(mon_word);
                mon_words++;
            end
            csn_prev = csn;
            sck_prev = sck;
        end
    end

    // faults[p] = 1 means the fault line is active at the end of pass p.
    task automatic run_seq(input string name, input logic [MAX_RETRY:0] faults, input int glitch_at);
        int passes;
        bit ok;
        int cyc;
        int csn_at;
        int pidx;
        int nexp;
        passes = 0;
        ok = 0;
        for (int p = 0; p <= MAX_RETRY; p++) begin
            passes++;
            if (!faults[p]) begin
                ok = 1;
                break;
            end
        end
        nexp = passes * NUM_WORDS;
        got_q.delete();
        mon_words = 0;
        nerror = 1'b1;
        cyc = 0;
        csn_at = 0;
        @(negedge clk);
        start = 1'b1;
        while (!(done || fail) && cyc < 4*PASS_CYC) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (csn_at == 0 && !csn) csn_at = cyc;
            pidx = (mon_words == 0) ? 0 : (mon_words - 1) / NUM_WORDS;
            if (pidx > MAX_RETRY) pidx = MAX_RETRY;
            nerror = !faults[pidx];
            if (cyc == glitch_at) start = 1'b0;
            if (cyc == glitch_at + 1) start = 1'b1;
        end
        $display("run %s: faults=%b glitch=%0d passes=%0d words=%0d cycles=%0d done=%0b fail=%0b",
                 name, faults, glitch_at, passes, got_q.size(), cyc, done, fail);
        check_val("pass_cycles", cyc, 1 + passes*PASS_CYC);
        check_val("csn_latency", csn_at, 2);
        check_val("done_flag", done, ok);
        check_val("fail_flag", fail, !ok);
        check_val("busy_end", busy, 0);
        check_val("word_count", got_q.size(), nexp);
        for (int i = 0; i < nexp && i < got_q.size(); i++)
            check_val("word_value", got_q[i], ref_table[i % NUM_WORDS]);
        repeat (20) @(negedge clk);
        check_val("hold_done", done, ok);
        check_val("hold_fail", fail, !ok);
        check_val("hold_no_rerun", got_q.size(), nexp);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("clear_done", done, 0);
        check_val("clear_fail", fail, 0);
        @(negedge clk);
        check_val("idle_busy", busy, 0);
    endtask

    initial begin
        int cyc;
        int nb;
        int hi_cnt;
        logic [7:0] pat;
        logic sprev;
        logic [MAX_RETRY:0] fr;
        int gl;

        resetb = 1'b0; start = 1'b0; nerror = 1'b1;
        s_start = 1'b0; s_nerror = 1'b1;
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
        check_val("rst_csn", csn, 1);
        check_val("rst_sck", sck, 0);
        check_val("rst_mosi", mosi, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_fail", fail, 0);

        run_seq("clean", 3'b000, 0);
        run_seq("fault_clear", 3'b001, 0);
        run_seq("persist_fault", 3'b111, 0);

        // reset in the middle of word 1
        @(negedge clk);
        got_q.delete();
        mon_words = 0;
        nerror = 1'b1;
        start = 1'b1;
        cyc = 0;
        while (!(mon_words == 1 && mon_bits == 7) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check_val("reach_word1_bit7", cyc < 2000, 1);
        resetb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        $display("reset mid-word: csn=%0b sck=%0b busy=%0b", csn, sck, busy);
        check_val("midrst_csn", csn, 1);
        check_val("midrst_sck", sck, 0);
        check_val("midrst_busy", busy, 0);
        check_val("midrst_mosi", mosi, 0);
        start = 1'b0;
        @(negedge clk);
        resetb = 1'b1;
        repeat (3) @(negedge clk);
        run_seq("after_reset", 3'b000, 0);

        run_seq("glitch", 3'b000, 137);
        for (int r = 0; r < 5; r++) begin
            fr = MAX_RETRY'(0) | 3'($urandom_range(0, 7));
            gl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 500)) : 0;
            run_seq("random", fr, gl);
        end

        // CLK_DIV=1, 8-bit single word 0x81
        @(negedge clk);
        s_start = 1'b1;
        cyc = 0; nb = 0; hi_cnt = 0; pat = '0; sprev = 1'b0;
        while (!s_done && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (s_sck && !sprev) begin
                pat = {pat[6:0], s_mosi};
                nb++;
            end
            if (s_sck) hi_cnt++;
            sprev = s_sck;
        end
        $display("small run: cycles=%0d bits=%0d pattern=0x%0h", cyc, nb, pat);
        check_val("small_cycles", cyc, 29);
        check_val("small_bits", nb, 8);
        check_val("small_sck_high", hi_cnt, 8);
        check_val("small_pattern", pat, 8'h81);
        check_val("small_fail", s_fail, 0);
        s_start = 1'b0;
        repeat (2) @(negedge clk);
        check_val("small_clear", s_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
